uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, frame options and received-word outputs of the UART receiver
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with majority-vote bit sampling and optional parity
module uart_rx #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    uart_rx_if.slave   bus
);
    localparam int EW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [EW-1:0] MID_LO   = EW'(OVERSAMPLE / 2 - 1);
    localparam logic [EW-1:0] MID      = EW'(OVERSAMPLE / 2);
    localparam logic [EW-1:0] MID_HI   = EW'(OVERSAMPLE / 2 + 1);
    localparam logic [EW-1:0] LAST     = EW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nxt;
    logic                  rx_meta, rx_s;
    logic [EW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg, p_data_q;
    logic [DATA_WIDTH:0]   shift_in;
    logic                  samp_lo, samp_mid, maj;
    logic                  par_en_l, par_typ_l, par_acc, par_pend, stop_bit;
    logic                  dv_q, pe_q, se_q;
    logic                  dv_nxt, pe_nxt, se_nxt;
    logic                  bit_wrap, at_vote;

    assign maj      = (samp_lo & samp_mid) | (samp_lo & rx_s) | (samp_mid & rx_s);
    assign bit_wrap = (edge_cnt == LAST);
    assign at_vote  = (edge_cnt == MID_HI);
    assign shift_in = {maj, shift_reg};

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = dv_q;
    assign bus.par_err    = pe_q;
    assign bus.stp_err    = se_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.RX_IN;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The detecting IDLE cycle is sample 0 of the start bit, so a frame
    // streamed back-to-back is picked up in the flag cycle itself.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            START: begin
                if (at_vote && maj) state_nxt = IDLE;
                else if (bit_wrap)  state_nxt = DATA;
            end
            DATA:    if (bit_wrap && bit_cnt == BIT_LAST) state_nxt = par_en_l ? PARITY : STOP;
            PARITY:  if (bit_wrap) state_nxt = STOP;
            STOP:    if (bit_wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dv_nxt = 1'b0;
        pe_nxt = 1'b0;
        se_nxt = 1'b0;
        if (state == STOP && bit_wrap) begin
            if (!stop_bit)     se_nxt = 1'b1;
            else if (par_pend) pe_nxt = 1'b1;
            else               dv_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
            samp_lo   <= 1'b1;
            samp_mid  <= 1'b1;
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
            par_acc   <= 1'b0;
            par_pend  <= 1'b0;
            stop_bit  <= 1'b1;
        end else begin
            dv_q <= dv_nxt;
            pe_q <= pe_nxt;
            se_q <= se_nxt;
            if (dv_nxt) p_data_q <= shift_reg;

            edge_cnt <= (state_nxt == IDLE) ? '0 : edge_cnt + EW'(1);

            if (edge_cnt == MID_LO) samp_lo  <= rx_s;
            if (edge_cnt == MID)    samp_mid <= rx_s;

            if (state == IDLE && !rx_s) begin
                par_en_l  <= bus.PAR_EN;
                par_typ_l <= bus.PAR_TYP;
                par_acc   <= 1'b0;
                par_pend  <= 1'b0;
            end

            if (at_vote) begin
                case (state)
                    DATA: begin
                        shift_reg <= shift_in[DATA_WIDTH:1];
                        par_acc   <= par_acc ^ maj;
                    end
                    PARITY:  par_pend <= ((par_acc ^ maj) != par_typ_l);
                    STOP:    stop_bit <= maj;
                    default: ;
                endcase
            end

            if (state != DATA)
                bit_cnt <= '0;
            else if (bit_wrap)
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx with a scoreboard of expected frame outcomes
module tb_uart_rx;
    localparam int OS = 8;
    localparam int K_DV = 0, K_PE = 1, K_SE = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;
    exp_t sb[$];
    logic [7:0] last_good;
    logic [7:0] prev_pdata;

    uart_rx_if #(.DATA_WIDTH(8)) bus ();

    uart_rx #(.OVERSAMPLE(OS), .DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int   nf;
        exp_t e;
        if (!rst) begin
            nf = int'(bus.data_valid) + int'(bus.par_err) + int'(bus.stp_err);
            if (nf != 0) begin
                checks++;
                assert (nf === 1) else begin errors++; $error("FAIL flags_exclusive observed=%0d expected=1", nf); end
                checks++;
                assert (sb.size() != 0) else begin errors++; $error("FAIL unexpected_flag observed=%0d expected=0 pending at cyc %0d", nf, cyc); end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checks++;
                    assert ((bus.stp_err ? K_SE : bus.par_err ? K_PE : K_DV) === e.kind)
                        else begin errors++; $error("FAIL flag_kind observed=%b%b%b expected kind=%0d", bus.data_valid, bus.par_err, bus.stp_err, e.kind); end
                    checks++;
                    assert (bus.P_DATA === e.data) else begin errors++; $error("FAIL p_data observed=%h expected=%h", bus.P_DATA, e.data); end
                    checks++;
                    assert (cyc === e.cyc) else begin errors++; $error("FAIL latency observed_cyc=%0d expected_cyc=%0d", cyc, e.cyc); end
                end
            end
            if (bus.P_DATA !== prev_pdata) begin
                checks++;
                assert (bus.data_valid === 1'b1) else begin errors++; $error("FAIL p_data_hold observed=%h expected=%h", bus.P_DATA, prev_pdata); end
            end
        end
        prev_pdata = bus.P_DATA;
    end

    task automatic send_bit(input logic v, input int flip_at);
        for (int j = 0; j < OS; j++) begin
            bus.RX_IN = (j == flip_at) ? ~v : v;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_flag(input int kind, input logic [7:0] data, input int at);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Option inputs are flipped after the start bit: the frame must use the values seen at start.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic par_flip, input logic stop_v, input int glitch_bit);
        logic p;
        int   dc;
        p  = (^d) ^ pt ^ par_flip;
        dc = cyc + 2 + (2 + 8 + int'(pe)) * OS;
        if (!stop_v)              expect_flag(K_SE, last_good, dc);
        else if (pe && par_flip)  expect_flag(K_PE, last_good, dc);
        else begin
            expect_flag(K_DV, d, dc);
            last_good = d;
        end
        bus.PAR_EN  = pe;
        bus.PAR_TYP = pt;
        send_bit(1'b0, -1);
        bus.PAR_EN  = ~pe;
        bus.PAR_TYP = ~pt;
        for (int i = 0; i < 8; i++) send_bit(d[i], (glitch_bit == i) ? OS / 2 : -1);
        if (pe) send_bit(p, -1);
        send_bit(stop_v, -1);
    endtask

    initial begin
        int dc;
        cyc         = 0;
        errors      = 0;
        checks      = 0;
        last_good   = 8'h00;
        rst         = 1'b1;
        bus.RX_IN   = 1'b1;
        bus.PAR_EN  = 1'b0;
        bus.PAR_TYP = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; assert (bus.P_DATA === 8'h00)     else begin errors++; $error("FAIL reset_p_data observed=%h expected=00", bus.P_DATA); end
        checks++; assert (bus.data_valid === 1'b0)  else begin errors++; $error("FAIL reset_dv observed=%b expected=0", bus.data_valid); end
        checks++; assert (bus.par_err === 1'b0)     else begin errors++; $error("FAIL reset_pe observed=%b expected=0", bus.par_err); end
        checks++; assert (bus.stp_err === 1'b0)     else begin errors++; $error("FAIL reset_se observed=%b expected=0", bus.stp_err); end
        idle(10);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(12);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        idle(12);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        idle(12);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        idle(12);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(20);

        // Short low glitch on the idle line, then a data bit inverted at its centre sample.
        bus.RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        idle(30);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        idle(12);

        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(12);

        // Break: stop error, then the still-low line starts a new frame reading 0xFE.
        bus.PAR_EN = 1'b0;
        dc = cyc + 2 + 10 * OS;
        expect_flag(K_SE, last_good, dc);
        expect_flag(K_DV, 8'hFE, dc + 10 * OS);
        last_good = 8'hFE;
        bus.RX_IN = 1'b0;
        repeat (12 * OS) @(negedge clk);
        idle(12 * OS);

        // Reset during data bit 4 aborts the frame silently.
        bus.PAR_EN = 1'b0;
        send_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) send_bit(i[0], -1);
        bus.RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.RX_IN = 1'b1;
        last_good = 8'h00;
        checks++; assert (bus.P_DATA === 8'h00)    else begin errors++; $error("FAIL midreset_p_data observed=%h expected=00", bus.P_DATA); end
        checks++; assert (bus.data_valid === 1'b0) else begin errors++; $error("FAIL midreset_dv observed=%b expected=0", bus.data_valid); end
        idle(20);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(200);

        checks++;
        assert (sb.size() === 0) else begin errors++; $error("FAIL missing_flags observed=%0d expected=0 outstanding", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
